// File: rtl/branch_predictor.sv
// branch_predictor -- fetch-stage direction predictor.
//
// A table of 2-bit saturating counters, indexed by pc[INDEX_BITS+1:2],
// supplies a same-cycle taken/not-taken guess to the next-PC mux. Each
// guess is carried PIPE_DEPTH stages to execute. There it is compared with
// the resolved outcome to raise mispredict, and the table is trained.
//
// Optional build macro: BP_TAG_EN. When defined, every entry holds a valid
// bit and a tag (pc[PC_WIDTH-1:INDEX_BITS+2]). A lookup that misses guesses
// not-taken. A resolution that misses allocates the entry.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   guess_valid     fetch holds a predecoded conditional branch
//   guess_pc        PC of the fetched instruction
//   guess_taken     predicted direction (combinational, 0 when !guess_valid)
//   check_valid     a branch resolves in execute this cycle
//   check_pc        PC of the resolving branch
//   check_taken     resolved direction
//   stall           freeze: no pipe advance, no table update
//   flush           squash all in-flight guesses
//   mispredict      resolved direction != carried guess (combinational)
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 5,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                guess_valid,
  input  logic [PC_WIDTH-1:0] guess_pc,
  output logic                guess_taken,
  input  logic                check_valid,
  input  logic [PC_WIDTH-1:0] check_pc,
  input  logic                check_taken,
  input  logic                stall,
  input  logic                flush,
  output logic                mispredict
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [ENTRIES-1:0][1:0]  ctr_q, ctr_d;
  logic [PIPE_DEPTH-1:0]    vld_pipe_q, vld_pipe_d;
  logic [PIPE_DEPTH-1:0]    dir_pipe_q, dir_pipe_d;
  logic [INDEX_BITS-1:0]    g_idx, c_idx;
  logic                     g_hit, c_hit;
  logic                     upd_en;

  assign g_idx  = guess_pc[INDEX_BITS+1:2];
  assign c_idx  = check_pc[INDEX_BITS+1:2];
  assign upd_en = check_valid & ~stall;

`ifdef BP_TAG_EN
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0]            tvld_q, tvld_d;
  logic                          unused_pc;

  assign g_hit = tvld_q[g_idx] && (tag_q[g_idx] == guess_pc[PC_WIDTH-1:INDEX_BITS+2]);
  assign c_hit = tvld_q[c_idx] && (tag_q[c_idx] == check_pc[PC_WIDTH-1:INDEX_BITS+2]);
  assign unused_pc = ^{guess_pc[1:0], check_pc[1:0]};

  // A resolution that misses claims the entry for the resolving PC.
  always_comb begin
    tag_d  = tag_q;
    tvld_d = tvld_q;
    if (upd_en && !c_hit) begin
      tvld_d[c_idx] = 1'b1;
      tag_d[c_idx]  = check_pc[PC_WIDTH-1:INDEX_BITS+2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      tvld_q <= '0;
    end else begin
      tag_q  <= tag_d;
      tvld_q <= tvld_d;
    end
  end
`else
  logic unused_pc;

  // Untagged: aliasing PCs share a counter, so every lookup hits.
  assign g_hit = 1'b1;
  assign c_hit = 1'b1;
  assign unused_pc = ^{guess_pc[PC_WIDTH-1:INDEX_BITS+2], guess_pc[1:0],
                       check_pc[PC_WIDTH-1:INDEX_BITS+2], check_pc[1:0]};
`endif

  // The read uses the registered table, so a same-cycle update to the
  // same index is not visible until the next cycle.
  assign guess_taken = guess_valid & g_hit & ctr_q[g_idx][1];

  // An empty execute slot compares as a not-taken guess.
  assign mispredict = upd_en &
                      (check_taken != (vld_pipe_q[PIPE_DEPTH-1] & dir_pipe_q[PIPE_DEPTH-1]));

  // Flush does not gate training: the resolving branch is older than
  // whatever caused the flush.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      if (c_hit) ctr_d[c_idx] = check_taken ? sat_inc(ctr_q[c_idx]) : sat_dec(ctr_q[c_idx]);
      else       ctr_d[c_idx] = check_taken ? 2'b10 : 2'b01;
    end
  end

  // Flush takes priority over stall for the prediction pipe only.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    dir_pipe_d = dir_pipe_q;
    if (flush) begin
      vld_pipe_d = '0;
      dir_pipe_d = '0;
    end else if (!stall) begin
      vld_pipe_d[0] = guess_valid;
      dir_pipe_d[0] = guess_taken;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        dir_pipe_d[k] = dir_pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q      <= {ENTRIES{2'b01}};
      vld_pipe_q <= '0;
      dir_pipe_q <= '0;
    end else begin
      ctr_q      <= ctr_d;
      vld_pipe_q <= vld_pipe_d;
      dir_pipe_q <= dir_pipe_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default parameters, PIPE_DEPTH=2).
// Inputs change on the falling edge, outputs are sampled 1ns later, and
// state advances on the rising edge. Every cycle is "drv + check + tick".
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        guess_valid;
  logic [31:0] guess_pc;
  logic        guess_taken;
  logic        check_valid;
  logic [31:0] check_pc;
  logic        check_taken;
  logic        stall;
  logic        flush;
  logic        mispredict;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .guess_valid (guess_valid),
    .guess_pc    (guess_pc),
    .guess_taken (guess_taken),
    .check_valid (check_valid),
    .check_pc    (check_pc),
    .check_taken (check_taken),
    .stall       (stall),
    .flush       (flush),
    .mispredict  (mispredict)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drv(input logic gv, input logic [31:0] gpc, input logic cv,
                     input logic [31:0] cpc, input logic ct, input logic st,
                     input logic fl);
    guess_valid = gv;  guess_pc = gpc;
    check_valid = cv;  check_pc = cpc;  check_taken = ct;
    stall = st;        flush = fl;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Resolves pc n times with direction t, no guesses in flight.
  task automatic train(input logic [31:0] pc, input logic t, input int n);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, 32'h0, 1'b1, pc, t, 1'b0, 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_guess", guess_taken, 1'b0);
    chk("rst_mp", mispredict, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();

    // Basic training at 0x100 and asynchronous reset mid-operation.
    do_reset();
    drv(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("g100_init", guess_taken, 1'b0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("mp_empty_taken", mispredict, 1'b1);
    tick();
    train(32'h100, 1'b1, 1);
    drv(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("g100_trained", guess_taken, 1'b1);
    tick();
    train(32'h100, 1'b0, 1);
    drv(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("g100_ctr10", guess_taken, 1'b1);
    tick();
    train(32'h100, 1'b0, 1);
    drv(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("g100_ctr01", guess_taken, 1'b0);
    tick();
    train(32'h100, 1'b1, 1);
    drv(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("g100_pre_rst", guess_taken, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("g100_async_rst", guess_taken, 1'b0);
    tick();
    rst_n = 1'b1;
    drv(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("mp_after_rst", mispredict, 1'b0);
    tick();

    // Saturation at 0x104.
    do_reset();
    train(32'h104, 1'b1, 5);
    train(32'h104, 1'b0, 1);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_11_to_10", guess_taken, 1'b1);
    tick();
    train(32'h104, 1'b0, 1);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_10_to_01", guess_taken, 1'b0);
    tick();
    train(32'h104, 1'b0, 2);
    train(32'h104, 1'b1, 1);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_00_plus1", guess_taken, 1'b0);
    tick();
    train(32'h104, 1'b1, 1);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_00_plus2", guess_taken, 1'b1);
    tick();

    // Pipe timing: the guess reaches execute two edges after fetch.
    do_reset();
    drv(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pipe_g200", guess_taken, 1'b0);
    tick();
    idle();
    chk("pipe_no_check", mispredict, 1'b0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("pipe_mp_taken", mispredict, 1'b1);
    tick();
    idle();
    chk("pipe_mp_gone", mispredict, 1'b0);
    train(32'h104, 1'b1, 2);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pipe_g104", guess_taken, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    chk("pipe_one_edge_empty", mispredict, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    chk("pipe_two_edge_hit", mispredict, 1'b0);
    tick();
    idle();

    // Stall freezes the pipe and the table.
    do_reset();
    train(32'h104, 1'b1, 2);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_g104", guess_taken, 1'b1);
    tick();
    idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
      chk($sformatf("stall_mp_%0d", i), mispredict, 1'b0);
      tick();
    end
    drv(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    chk("stall_release_mp", mispredict, 1'b1);
    tick();
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_tbl_held", guess_taken, 1'b1);
    tick();
    idle();

    // Flush empties the pipe but does not block training.
    do_reset();
    train(32'h104, 1'b1, 2);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_g104", guess_taken, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b1);
    chk("flush_cycle_mp", mispredict, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    chk("flush_empty_nt", mispredict, 1'b0);
    tick();
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_dec1", guess_taken, 1'b1);
    tick();
    train(32'h104, 1'b0, 1);
    drv(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_dec2", guess_taken, 1'b0);
    tick();
    drv(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_upd_kept", guess_taken, 1'b1);
    tick();
    idle();
    tick();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    chk("flush_over_stall", mispredict, 1'b0);
    tick();
    idle();

    // Same-cycle read and update of one index returns the old value.
    do_reset();
    drv(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    chk("rw_same_cycle", guess_taken, 1'b0);
    tick();
    drv(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rw_next_cycle", guess_taken, 1'b1);
    tick();

    // Aliasing between 0x000 and 0x080.
    do_reset();
    train(32'h000, 1'b1, 2);
    drv(1'b1, 32'h000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("alias_own", guess_taken, 1'b1);
    drv(1'b1, 32'h080, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef BP_TAG_EN
    chk("alias_other", guess_taken, 1'b0);
`else
    chk("alias_other", guess_taken, 1'b1);
`endif
    tick();
    train(32'h080, 1'b1, 1);
    drv(1'b1, 32'h080, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("alias_080_taken", guess_taken, 1'b1);
    drv(1'b1, 32'h000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef BP_TAG_EN
    chk("alias_000_evicted", guess_taken, 1'b0);
`else
    chk("alias_000_shared", guess_taken, 1'b1);
`endif
    tick();
    train(32'h080, 1'b0, 1);
    drv(1'b1, 32'h080, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef BP_TAG_EN
    chk("alias_alloc_10", guess_taken, 1'b0);
`else
    chk("alias_shared_11", guess_taken, 1'b1);
`endif
    tick();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
